// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle control unit sequencing a shared 16-bit ALU
// through fetch, decode, execute, writeback and PC increment.
module alu_sequencer #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  alu_fn,
    output logic        alu_x_sel,
    input  logic [15:0] alu_z,
    input  logic        alu_carry,
    input  logic        alu_carry_n_1,
    output logic [2:0]  reg_raddr_a,
    output logic [2:0]  reg_raddr_b,
    output logic [2:0]  reg_waddr,
    output logic        reg_we,
    output logic        flag_c,
    output logic        flag_v,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_PCINC  = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic [2:0]  state;
    logic [15:0] pc;
    logic [15:0] ir;

    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic       is_binary;
    logic       updates_flags;
    logic       ir_unused;

    assign opcode        = ir[15:12];
    assign rd            = ir[11:9];
    assign rs            = ir[8:6];
    assign is_binary     = (opcode == 4'd3) || (opcode == 4'd5);
    assign updates_flags = (opcode >= 4'd1) && (opcode <= 4'd4);
    assign ir_unused     = ^ir[5:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            pc     <= PC_RESET;
            ir     <= 16'h0000;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == 4'd7)   state <= S_HALT;
                    else if (opcode[3])   state <= S_PCINC;
                    else                  state <= S_EXEC;
                end
                S_EXEC: begin
                    if (updates_flags) begin
                        flag_c <= alu_carry;
                        flag_v <= alu_carry ^ alu_carry_n_1;
                    end
                    state <= S_WB;
                end
                S_WB: state <= S_PCINC;
                S_PCINC: begin
                    pc    <= alu_z;
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // All control outputs are decoded from the current state so they are valid for the whole cycle.
    always_comb begin
        mem_req     = (state == S_FETCH);
        busy        = (state != S_IDLE) && (state != S_HALT);
        halted      = (state == S_HALT);
        illegal     = (state == S_DECODE) && opcode[3];
        alu_fn      = 3'b000;
        alu_x_sel   = 1'b0;
        reg_raddr_a = 3'd0;
        reg_raddr_b = 3'd0;
        reg_waddr   = 3'd0;
        reg_we      = 1'b0;
        case (state)
            S_EXEC, S_WB: begin
                alu_fn      = opcode[2:0];
                reg_raddr_a = is_binary ? rd : rs;
                reg_raddr_b = rs;
                if (state == S_WB) begin
                    reg_we    = 1'b1;
                    reg_waddr = rd;
                end
            end
            S_PCINC: begin
                alu_fn    = 3'b001;
                alu_x_sel = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr = pc;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with behavioural
// ALU, register file and instruction memory around the DUT.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [2:0]  alu_fn;
    logic        alu_x_sel;
    logic [15:0] alu_z;
    logic        alu_carry;
    logic        alu_carry_n_1;
    logic [2:0]  reg_raddr_a;
    logic [2:0]  reg_raddr_b;
    logic [2:0]  reg_waddr;
    logic        reg_we;
    logic        flag_c;
    logic        flag_v;
    logic        busy;
    logic        halted;
    logic        illegal;

    always #5 clk = ~clk;

    alu_sequencer #(.PC_RESET(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_fn(alu_fn), .alu_x_sel(alu_x_sel), .alu_z(alu_z),
        .alu_carry(alu_carry), .alu_carry_n_1(alu_carry_n_1),
        .reg_raddr_a(reg_raddr_a), .reg_raddr_b(reg_raddr_b),
        .reg_waddr(reg_waddr), .reg_we(reg_we),
        .flag_c(flag_c), .flag_v(flag_v),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    // Environment: register file with a preload port, and the shared ALU.
    logic [15:0] rf [8];
    logic        pl_we = 1'b0;
    logic [2:0]  pl_addr = 3'd0;
    logic [15:0] pl_data = 16'h0000;

    always @(posedge clk) begin
        if (pl_we)       rf[pl_addr]   <= pl_data;
        else if (reg_we) rf[reg_waddr] <= alu_z;
    end

    logic [15:0] ax, ay, lo;
    logic [16:0] sum;
    always_comb begin
        ax  = alu_x_sel ? mem_addr : rf[reg_raddr_a];
        ay  = rf[reg_raddr_b];
        sum = {1'b0, ax};
        lo  = 16'h0000;
        case (alu_fn)
            3'b001: begin sum = {1'b0, ax} + 17'd1;            lo = {1'b0, ax[14:0]} + 16'd1; end
            3'b010: begin sum = {1'b0, ax} + 17'h0FFFF;        lo = {1'b0, ax[14:0]} + 16'h7FFF; end
            3'b011: begin sum = {1'b0, ax} + {1'b0, ay};       lo = {1'b0, ax[14:0]} + {1'b0, ay[14:0]}; end
            3'b100: begin sum = {1'b0, ~ax} + 17'd1;           lo = {1'b0, ~ax[14:0]} + 16'd1; end
            3'b101: sum = {1'b0, ax | ay};
            3'b110: sum = {1'b0, ~ax};
            default: ;
        endcase
    end
    assign alu_z         = sum[15:0];
    assign alu_carry     = sum[16];
    assign alu_carry_n_1 = lo[15];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: architectural state plus expected retire events.
    typedef struct {
        int          kind;      // 0 write, 1 illegal, 2 halt
        logic [2:0]  waddr;
        logic [15:0] data;
        logic [2:0]  fn;
        logic        c;
        logic        v;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_r [8];
    logic [15:0] m_pc = 16'hFFFF;
    logic        m_c = 1'b0;
    logic        m_v = 1'b0;

    task automatic model_issue(input logic [15:0] ins);
        exp_t        e;
        logic [3:0]  op;
        logic [2:0]  rd, rs;
        logic [15:0] x, y, r;
        int          s;
        op = ins[15:12];
        rd = ins[11:9];
        rs = ins[8:6];
        e.pc = m_pc; e.waddr = rd; e.fn = op[2:0]; e.data = 16'h0000;
        if (op == 4'd7) begin
            e.kind = 2;
        end else if (op >= 4'd8) begin
            e.kind = 1;
            m_pc = m_pc + 16'd1;
        end else begin
            e.kind = 0;
            x = (op == 4'd3 || op == 4'd5) ? m_r[rd] : m_r[rs];
            y = m_r[rs];
            case (op)
                4'd0: r = x;
                4'd1: r = x + 16'd1;
                4'd2: r = x - 16'd1;
                4'd3: r = x + y;
                4'd4: r = 16'd0 - x;
                4'd5: r = x | y;
                default: r = ~x;
            endcase
            case (op)
                4'd1: begin m_c = (x == 16'hFFFF); m_v = (x == 16'h7FFF); end
                4'd2: begin m_c = (x != 16'h0000); m_v = (x == 16'h8000); end
                4'd3: begin
                    s   = int'($signed(x)) + int'($signed(y));
                    m_c = (int'(x) + int'(y)) > 65535;
                    m_v = (s > 32767) || (s < -32768);
                end
                4'd4: begin m_c = (x == 16'h0000); m_v = (x == 16'h8000); end
                default: ;
            endcase
            m_r[rd] = r;
            e.data  = r;
            m_pc    = m_pc + 16'd1;
        end
        e.c = m_c;
        e.v = m_v;
        exp_q.push_back(e);
    endtask

    // Monitor: every write strobe, illegal pulse and halt entry retires one expected event.
    task automatic check_event(input int k);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected no event", k);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_pc", mem_addr, e.pc);
        if (k == 0) begin
            chk("wb_waddr", reg_waddr, e.waddr);
            chk("wb_data", alu_z, e.data);
            chk("wb_alu_fn", alu_fn, e.fn);
            chk("wb_flag_c", flag_c, e.c);
            chk("wb_flag_v", flag_v, e.v);
        end else if (k == 1) begin
            chk("ill_flag_c", flag_c, e.c);
            chk("ill_flag_v", flag_v, e.v);
            chk("ill_reg_we", reg_we, 0);
        end else begin
            chk("halt_busy", busy, 0);
        end
    endtask

    logic prev_h = 1'b0;
    always @(negedge clk) begin
        if (reg_we)             check_event(0);
        if (illegal)            check_event(1);
        if (halted && !prev_h)  check_event(2);
        prev_h = halted;
    end

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step(1);
        pl_we = 1'b0;
        m_r[a] = d;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!mem_req && n < 20) begin
            step(1);
            n++;
        end
        if (!mem_req) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: got mem_req %0b expected 1 within 20 cycles", mem_req);
        end
    endtask

    task automatic serve(input logic [15:0] ins, input int wt);
        logic [15:0] a0;
        wait_fetch();
        if (!mem_req) return;
        a0 = mem_addr;
        model_issue(ins);
        for (int i = 0; i < wt; i++) begin
            mem_rdata = {4'hF, 12'($urandom)};
            step(1);
            chk("wait_mem_req", mem_req, 1);
            chk("wait_mem_addr", mem_addr, a0);
        end
        mem_ack = 1'b1;
        mem_rdata = ins;
        step(1);
        mem_ack = 1'b0;
        mem_rdata = {4'hF, 12'($urandom)};
        chk("req_drop", mem_req, 0);
    endtask

    task automatic chk_reset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_alu_fn", alu_fn, 0);
        chk("rst_alu_x_sel", alu_x_sel, 0);
        chk("rst_addrs", {reg_raddr_a, reg_raddr_b, reg_waddr}, 0);
        chk("rst_flags", {flag_c, flag_v}, 0);
        chk("rst_mem_addr", mem_addr, 16'hFFFF);
    endtask

    task automatic do_start();
        chk("pre_start_busy", busy, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_mem_req", mem_req, 1);
    endtask

    function automatic logic [15:0] rand_legal();
        logic [3:0] op;
        op = 4'($urandom_range(0, 6));
        return {op, 3'($urandom), 3'($urandom), 6'($urandom)};
    endfunction

    logic [15:0] pick [4];

    initial begin
        pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'hFFFF; pick[3] = 16'h0000;
        for (int i = 0; i < 8; i++) preload(3'(i), (i == 1) ? 16'h0005 : 16'($urandom));
        reset = 1'b0;
        step(1);
        chk_reset();
        do_start();

        // MOV at PC_RESET=FFFF wraps the pc to 0000.
        serve(16'h0440, 0);
        wait_fetch();
        chk("pc_wrap", mem_addr, 16'h0000);

        // ADD R1,R1 with zero wait: cycle-by-cycle control.
        serve(16'h3240, 0);
        chk("dec_reg_we", reg_we, 0);
        step(1);
        chk("exec_alu_fn", alu_fn, 3'b011);
        chk("exec_raddr", {reg_raddr_a, reg_raddr_b}, {3'd1, 3'd1});
        chk("exec_x_sel", alu_x_sel, 0);
        chk("exec_reg_we", reg_we, 0);
        step(1);
        chk("wb_reg_we", reg_we, 1);
        chk("wb_waddr1", reg_waddr, 3'd1);
        step(1);
        chk("pcinc_x_sel", alu_x_sel, 1);
        chk("pcinc_alu_fn", alu_fn, 3'b001);
        chk("pcinc_reg_we", reg_we, 0);
        step(1);
        chk("next_fetch_req", mem_req, 1);
        chk("next_fetch_addr", mem_addr, 16'h0001);
        chk("add_flag_c", flag_c, 0);

        serve(rand_legal(), 3);

        wait_fetch();
        preload(3'd3, 16'h7FFF);
        preload(3'd4, 16'h0001);
        serve(16'h3700, 0);
        step(3);
        chk("ovf_flag_v", flag_v, 1);
        chk("ovf_flag_c", flag_c, 0);

        wait_fetch();
        preload(3'd5, 16'hFFFF);
        serve(16'h1D40, 1);
        step(3);
        chk("inc_flag_c", flag_c, 1);
        chk("inc_result", rf[6], 16'h0000);

        while (m_pc != 16'h0010) serve(rand_legal(), $urandom_range(0, 2));
        wait_fetch();
        chk("ill_fetch_addr", mem_addr, 16'h0010);
        serve({4'h9, 12'($urandom)}, 0);
        chk("ill_pulse", illegal, 1);
        step(1);
        chk("ill_pulse_end", illegal, 0);
        chk("ill_pcinc", alu_x_sel, 1);
        chk("ill_no_we", reg_we, 0);
        step(1);
        chk("ill_next_addr", mem_addr, 16'h0011);
        chk("ill_flags_kept", {flag_c, flag_v}, {m_c, m_v});

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ins;
            ins = {4'($urandom_range(8, 15)), 12'($urandom)};
            if ($urandom_range(0, 3) != 0) ins = rand_legal();
            wait_fetch();
            if ($urandom_range(0, 2) == 0) preload(3'($urandom), pick[$urandom_range(0, 3)]);
            serve(ins, $urandom_range(0, 3));
        end

        serve(16'h7000, 0);
        step(1);
        chk("halt_halted", halted, 1);
        chk("halt_busy_low", busy, 0);
        start = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("halt_stays", {halted, busy, mem_req}, 3'b100);
            chk("halt_pc_frozen", mem_addr, m_pc);
        end
        start = 1'b0;
        mem_ack = 1'b0;

        // Reset during WB.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        m_pc = 16'hFFFF; m_c = 1'b0; m_v = 1'b0;
        step(1);
        chk_reset();
        do_start();
        serve(rand_legal(), 0);
        step(2);
        chk("wb_before_reset", reg_we, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        m_pc = 16'hFFFF; m_c = 1'b0; m_v = 1'b0;
        chk_reset();
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("post_reset_idle", {busy, mem_req, reg_we}, 3'b000);
        end

        do_start();
        for (int i = 0; i < 5; i++) serve(rand_legal(), $urandom_range(0, 3));
        serve(16'h7000, 1);
        step(2);
        chk("final_halted", halted, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control unit that sequences the shared 16-bit ALU through instruction fetch, decode, execute, writeback and PC increment. Sits between instruction memory, the register file and the ALU. Drives the ALU function select and operand muxes, and reuses the same ALU for PC increment. Latches ALU carry flags and reports halt and illegal-opcode status.

## Interface
Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin execution from IDLE; ignored in other states
- mem_req  out  1  instruction fetch request
- mem_addr  out  16  fetch address, equal to internal pc
- mem_ack  in  1  fetch data valid this cycle
- mem_rdata  in  16  instruction word, sampled when mem_req && mem_ack
- alu_fn  out  3  ALU function select (000 pass x, 001 x+1, 010 x-1, 011 x+y, 100 -x, 101 x|y, 110 ~x)
- alu_x_sel  out  1  ALU x mux: 0 = register read port A, 1 = pc
- alu_z  in  16  ALU result
- alu_carry, alu_carry_n_1  in  1 each  ALU carry out of bit 15 and bit 14
- reg_raddr_a, reg_raddr_b  out  3 each  register file read addresses
- reg_waddr  out  3  register file write address
- reg_we  out  1  register write strobe; write data is alu_z
- flag_c, flag_v  out  1 each  latched carry; overflow = carry ^ carry_n_1
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs, [5:0] ignored.
- Opcodes 0–6 map to alu_fn 000–110 in the same order. Opcode 7 is HALT. Opcodes 8–15 are illegal.
- Operands:
  - Unary ops (0, 1, 2, 4, 6): x = R[rs].
  - Binary ops (3 ADD, 5 OR): x = R[rd], y = R[rs].
  - reg_raddr_a is rs for unary ops and rd for binary ops. reg_raddr_b = rs.
  - Result is always written to rd.
- FSM states and transitions:
  - IDLE: start → FETCH.
  - FETCH: mem_req=1. On mem_ack, ir ← mem_rdata, → DECODE. Otherwise hold, keeping mem_req high.
  - DECODE: opcode 7 → HALT. Opcodes 8–15 → illegal=1, → PCINC. Otherwise → EXEC.
  - EXEC: alu_fn and read addresses from ir, alu_x_sel=0. At cycle end, flag_c ← alu_carry and flag_v ← alu_carry ^ alu_carry_n_1. Flags update only on opcodes 1–4. → WB.
  - WB: same alu_fn and addresses as EXEC, reg_we=1, reg_waddr=rd. → PCINC.
  - PCINC: alu_fn=001, alu_x_sel=1. pc ← alu_z (wraps FFFF→0000). → FETCH.
  - HALT: terminal. halted=1, pc frozen. Only reset exits.
- Outside EXEC/WB/PCINC: alu_fn=000 and alu_x_sel=0.
- mem_ack outside FETCH is ignored.
- start while busy or halted is ignored.

## Timing
- Reset values: state IDLE, pc=PC_RESET, ir=0, flag_c=flag_v=0. mem_req, reg_we, busy, halted and illegal all 0. alu_fn=000, alu_x_sel=0, all addresses 0.
- Reset has priority over every transition. Reset mid-instruction discards ir and performs no writeback.
- Legal instruction cost: 5 cycles plus memory wait (FETCH ≥1, DECODE 1, EXEC 1, WB 1, PCINC 1).
- Illegal instruction: 3 cycles plus wait; no register or flag change.
- mem_ack in the first FETCH cycle gives zero wait. DECODE follows on the next edge.
- mem_req is asserted from the first FETCH cycle until the ack cycle inclusive, then deasserts.
- reg_we is high for exactly one cycle per legal ALU instruction.
- alu_x_sel=1 only in PCINC.
- busy rises the cycle after start is sampled in IDLE.

## Test plan
- Reset, start, fetch 0x3240 (ADD rd=1, rs=1) with R1=0x0005 and a zero-wait ack. Required: reg_we in cycle 4 with waddr=1, alu_fn=011, pc becomes 0x0001 after PCINC, flag_c=0.
- Fetch with mem_ack delayed 3 cycles. Required: mem_req held 4 cycles, mem_addr stable, ir sampled only on the ack cycle.
- ADD with R[rd]=0x7FFF and R[rs]=0x0001. Required: flag_v=1, flag_c=0. Then INC on 0xFFFF: flag_c=1, result 0x0000.
- Opcode 0x9 at pc=0x0010. Required: illegal pulses for one cycle, no reg_we, flags unchanged, next fetch at 0x0011.
- PC wrap: PC_RESET=16'hFFFF with a MOV instruction. Required: pc=0x0000 after PCINC. HALT (0x7000) then sets halted=1 and busy=0; further start and ack are ignored.
- Assert reset during WB. Required: no reg_we in the following cycle, all outputs at reset values, IDLE until the next start.
